// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding and sector geometry for the SD sector reader.
package sd_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    WAIT_START = 3'd2,
    FILL       = 3'd3,
    WAIT_DONE  = 3'd4,
    DRAIN      = 3'd5,
    ABORT      = 3'd6
  } state_t;
  localparam int SECTOR_BYTES  = 512;
  localparam int SD_ADDR_SHIFT = 9;
endpackage

// File: rtl/sd_sector_ram.sv
// sd_sector_ram: simple dual-port sector buffer with a registered 1-cycle read.
module sd_sector_ram
  import sd_pkg::*;
#(
  parameter int DEPTH = SECTOR_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sd_sector_reader.sv
// sd_sector_reader: reads one SD sector through the SPI controller into a local
// buffer, then replays it as a backpressured byte stream.
module sd_sector_reader
  import sd_pkg::*;
#(
  parameter bit BLOCK_ADDR     = 1'b0,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int SECTOR_BYTES   = sd_pkg::SECTOR_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_sector,
  input  logic        sd_ready,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err_timeout,
  output logic [2:0]  status
);
  localparam int AW = $clog2(SECTOR_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, next;
  logic [9:0]    wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    ram_q;
  logic ba_q, accept, rise, we, fire, tmo_hit, last_wr;

  assign req_ready = state == IDLE && !reset;
  assign accept    = req_valid && req_ready;
  assign rise      = sd_byte_available && !ba_q;
  assign we        = state == FILL && rise;
  assign last_wr   = wr_cnt == 10'(SECTOR_BYTES - 1);
  assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign fire      = m_valid && m_ready;
  assign m_last    = m_valid && rd_cnt == AW'(SECTOR_BYTES - 1);
  assign m_data    = m_valid ? ram_q : 8'd0;
  assign busy      = state != IDLE;
  assign status    = state;

  // Read address runs one ahead on a handshake so bytes stream back-to-back.
  sd_sector_ram #(.DEPTH(SECTOR_BYTES)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (sd_dout),
    .raddr (rd_cnt + AW'(fire)),
    .rdata (ram_q)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE:       next = accept ? WAIT_READY : IDLE;
      WAIT_READY: next = sd_ready ? WAIT_START : WAIT_READY;
      WAIT_START: next = !sd_ready ? FILL : tmo_hit ? ABORT : WAIT_START;
      FILL:       next = we ? (last_wr ? WAIT_DONE : sd_ready ? ABORT : FILL)
                            : (sd_ready || tmo_hit) ? ABORT : FILL;
      WAIT_DONE:  next = sd_ready ? DRAIN : WAIT_DONE;
      DRAIN:      next = (fire && m_last) ? IDLE : DRAIN;
      default:    next = IDLE;
    endcase
  end

  always_ff @(posedge clk) state <= reset ? IDLE : next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_rd       <= 1'b0;
      sd_address  <= '0;
      m_valid     <= 1'b0;
      err_timeout <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      tmo_cnt     <= '0;
      ba_q        <= 1'b0;
    end else begin
      ba_q    <= sd_byte_available;
      sd_rd   <= next == WAIT_START;
      m_valid <= state == DRAIN && !(fire && m_last);
      tmo_cnt <= (next != state || we) ? '0 : tmo_cnt + 1'b1;
      if (accept) begin
        sd_address  <= BLOCK_ADDR ? req_sector : req_sector << SD_ADDR_SHIFT;
        err_timeout <= 1'b0;
        wr_cnt      <= '0;
        rd_cnt      <= '0;
      end
      if (next == ABORT) err_timeout <= 1'b1;
      if (we) wr_cnt <= wr_cnt + 10'd1;
      if (fire) rd_cnt <= rd_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sd_sector_reader.sv
// tb_sd_sector_reader: controller BFM plus a sector-content scoreboard for both addressing modes.
module tb_sd_sector_reader;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, sd_ready = 1'b1;
  logic sd_byte_available = 1'b0, m_ready = 1'b0;
  logic [31:0] req_sector = '0;
  logic [7:0]  sd_dout = '0;

  logic        req_ready, sd_rd, m_valid, m_last, busy, err_timeout;
  logic [31:0] sd_address;
  logic [7:0]  m_data;
  logic [2:0]  status;
  logic        b_req_ready, b_sd_rd, b_m_valid, b_m_last, b_busy, b_err_timeout;
  logic [31:0] b_sd_address;
  logic [7:0]  b_m_data;
  logic [2:0]  b_status;

  sd_sector_reader #(.BLOCK_ADDR(1'b0), .TIMEOUT_CYCLES(1000)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sector(req_sector), .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_address(sd_address),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
    .err_timeout(err_timeout), .status(status)
  );

  sd_sector_reader #(.BLOCK_ADDR(1'b1), .TIMEOUT_CYCLES(1000)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_sector(req_sector), .sd_ready(sd_ready), .sd_rd(b_sd_rd), .sd_address(b_sd_address),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .m_valid(b_m_valid),
    .m_ready(m_ready), .m_data(b_m_data), .m_last(b_m_last), .busy(b_busy),
    .err_timeout(b_err_timeout), .status(b_status)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, hs = 0, base = 0, rmode = 0;
  bit exp_stream = 1'b0, stall_en = 1'b0, stalled = 1'b0;
  logic [7:0] exp_mem [512];
  logic [7:0] byte511 = '0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every presented byte must be the next sector byte, held while stalled.
  always @(negedge clk) begin
    if (reset) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
      end
      if (m_valid) begin
        if (!exp_stream || hs - base > 511) chk("unexpected_valid", m_valid, 0);
        else begin
          chk("m_data", m_data, exp_mem[hs-base]);
          chk("m_last", m_last, hs - base == 511);
          chk("b_m_valid", b_m_valid, 1);
          chk("b_m_data", b_m_data, exp_mem[hs-base]);
          chk("b_m_last", b_m_last, hs - base == 511);
          if (hs - base == 511) byte511 = m_data;
        end
        if (m_ready) hs++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en && !stalled && hs - base == 300) begin
      stalled = 1'b1;
      m_ready = 1'b0;
      repeat (100) @(posedge clk);
    end else m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !m_ready : 1'($urandom_range(0, 1));
  end

  task automatic chk_reset_vals(input logic rr);
    chk("rst_req_ready", req_ready, rr);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_address", sd_address, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_status", status, 0);
    chk("rst_b_req_ready", b_req_ready, rr);
    chk("rst_b_status", b_status, 0);
  endtask

  // mode 0: full sector, 1: controller stalls after nb bytes, 2: reset after nb bytes
  task automatic txn(input logic [31:0] sec, input int nb, input int hold, input bit pat, input int mode);
    int n;
    for (int i = 0; i < 512; i++) exp_mem[i] = pat ? 8'(i) : 8'($urandom);
    base = hs;
    exp_stream = (mode == 0);
    stalled = 1'b0;
    req_valid = 1'b1;
    req_sector = sec;
    tick;
    req_valid = 1'b0;
    chk("addr_byte", sd_address, sec << 9);
    chk("addr_block", b_sd_address, sec);
    chk("err_cleared", err_timeout, 0);
    chk("busy_on", busy, 1);
    n = 0;
    while (!sd_rd && n < 50) begin tick; n++; end
    chk("rd_rise", sd_rd, 1);
    repeat (3) begin tick; chk("rd_held", sd_rd, 1); end
    sd_ready = 1'b0;
    tick;
    chk("rd_drop", sd_rd, 0);
    chk("b_rd_drop", b_sd_rd, 0);
    for (int i = 0; i < nb; i++) begin
      repeat (16 - hold) tick;
      sd_dout = exp_mem[i];
      sd_byte_available = 1'b1;
      repeat (hold) tick;
      sd_byte_available = 1'b0;
    end
    if (mode == 0) begin
      repeat (40) tick;
      sd_ready = 1'b1;
      n = 0;
      while (hs - base < 512 && n < 5000) begin tick; n++; end
      tick;
      chk("handshakes", hs - base, 512);
      chk("busy_done", busy, 0);
      chk("req_ready_done", req_ready, 1);
      chk("err_ok", err_timeout, 0);
      chk("b_busy_done", b_busy, 0);
      if (pat) chk("byte511", byte511, 8'hFF);
    end else if (mode == 1) begin
      n = 0;
      while (!err_timeout && n < 3000) begin tick; n++; end
      chk("timeout_cycles", (n >= 980 && n <= 1010) ? 1000 : n, 1000);
      chk("err_set", err_timeout, 1);
      chk("b_err_set", b_err_timeout, 1);
      tick;
      chk("abort_idle", busy, 0);
      chk("abort_req_ready", req_ready, 1);
      chk("err_sticky", err_timeout, 1);
      chk("no_stream", hs - base, 0);
      sd_ready = 1'b1;
      tick;
    end else begin
      reset = 1'b1;
      tick;
      chk_reset_vals(1'b0);
      chk("no_stream_rst", hs - base, 0);
      reset = 1'b0;
      sd_ready = 1'b1;
      tick;
    end
    exp_stream = 1'b0;
  endtask

  initial begin
    tick;
    chk_reset_vals(1'b0);
    reset = 1'b0;
    #1;
    chk_reset_vals(1'b1);
    rmode = 0;
    txn(32'd5, 512, 1, 1'b1, 0);
    txn(32'h12345, 512, 1, 1'b0, 0);
    rmode = 1;
    stall_en = 1'b1;
    txn($urandom, 512, 1, 1'b0, 0);
    stall_en = 1'b0;
    rmode = 0;
    txn(32'd7, 100, 1, 1'b0, 1);
    txn(32'd9, 512, 1, 1'b0, 0);
    rmode = 2;
    txn($urandom, 512, 3, 1'b0, 0);
    txn(32'd11, 200, 1, 1'b0, 2);
    txn(32'd13, 512, 1, 1'b1, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sd_sector_reader.md
Name: sd_sector_reader

Overview:
- Sits directly upstream of the SD SPI controller's read port and downstream of any consumer that wants whole sectors, such as the file/asset loader.
- Accepts a sector-index request and converts it to the controller's address format.
- Drives the controller's rd/ready handshake and captures the 512 bytes that arrive on the per-byte strobe into a local sector buffer.
- Replays the buffer as a backpressured byte stream, because the controller cannot be stalled mid-block.

Parameters:
- BLOCK_ADDR, 0: 0 = byte addressing for SDSC cards (sd_address = sector<<9); 1 = block addressing for SDHC cards (sd_address = sector).
- TIMEOUT_CYCLES, 25_000_000: maximum clk cycles allowed in WAIT_START or between consecutive bytes in FILL before the request is aborted.
- SECTOR_BYTES, 512: bytes per sector; fixed by the SD protocol and not meant to be overridden.

Ports:
- clk  in  1  25 MHz system clock, shared with the controller.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  sector read request.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid&&req_ready.
- req_sector  in  32  sector index, sampled on acceptance.
- sd_ready  in  1  controller idle/ready flag.
- sd_rd  out  1  read enable to the controller.
- sd_address  out  32  registered address to the controller.
- sd_dout  in  8  controller data byte.
- sd_byte_available  in  1  controller new-byte strobe.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accept.
- m_data  out  8  output byte.
- m_last  out  1  high with byte 511.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky; cleared on the next accepted request.
- status  out  3  current state encoding, for debug.

Behaviour:
- Reset values: req_ready=0 in the reset cycle (IDLE from the next cycle), sd_rd=0, sd_address=0, m_valid=0, m_last=0, m_data=0, busy=0, err_timeout=0, counters=0, state=IDLE.
- Reset mid-operation drops sd_rd immediately, discards buffer contents, and returns to IDLE. The controller is reset by the same signal.
- IDLE:
  - req_ready=1.
  - On accept, latch the address: BLOCK_ADDR ? sector : {sector[22:0],9'b0}. Upper bits are truncated silently.
  - Clear err_timeout and the write counter, then go to WAIT_READY.
- WAIT_READY: wait for sd_ready=1, then set sd_rd=1 and go to WAIT_START.
- WAIT_START:
  - Hold sd_rd=1 until sd_ready=0, since the controller has left IDLE at that point. Then drop sd_rd the following cycle and go to FILL.
  - If sd_ready is not seen low within TIMEOUT_CYCLES, go to ABORT.
- FILL:
  - Capture on the rising edge of sd_byte_available, using a registered previous value. A strobe held high for several cycles therefore counts as one byte.
  - Write sd_dout to buf[wr_cnt] and increment wr_cnt (10 bits).
  - When the 512th byte is captured, go to WAIT_DONE.
  - If the inter-byte gap reaches TIMEOUT_CYCLES, go to ABORT.
  - If sd_ready returns to 1 with wr_cnt<512 (short block), go to ABORT.
- WAIT_DONE: wait for sd_ready=1, meaning the controller has consumed the CRC. Strobes seen here are ignored. Then go to DRAIN with rd_cnt=0.
- DRAIN:
  - Stream buf[rd_cnt] under a valid/ready handshake.
  - m_valid may rise no earlier than 1 cycle after entry, to allow for the synchronous RAM read latency.
  - m_data/m_valid/m_last stay stable while m_valid&&!m_ready.
  - Back-to-back transfers (1 byte/cycle) are required while m_ready=1, so the next address is prefetched.
  - m_last=1 only when rd_cnt=511.
  - After the byte-511 handshake, go to IDLE. req_ready is high on the next cycle.
- ABORT: set err_timeout=1, sd_rd=0, m_valid=0; no bytes are emitted; return to IDLE next cycle.
- Simultaneous events: req_valid outside IDLE is ignored, not queued. A byte strobe arriving in any state other than FILL is ignored.
- Exactly 512 bytes per successful request; the byte count never wraps.

Decomposition:
- The shared package sd_pkg holds:
  - the state enum (IDLE=0, WAIT_READY=1, WAIT_START=2, FILL=3, WAIT_DONE=4, DRAIN=5, ABORT=6);
  - SECTOR_BYTES=512;
  - SD_ADDR_SHIFT=9.
- One sub-module, sd_sector_ram: 512x8 simple dual-port RAM with a synchronous 1-cycle read, inferable as BRAM.

Test Plan:
1. Controller BFM (sd_ready drops 3 cycles after rd, bytes 0x00..0xFF,0x00..0xFF every 16 cycles, ready again 40 cycles after the last byte), req_sector=5, BLOCK_ADDR=0 -> sd_address=0x00000A00; the stream carries 512 bytes in order; m_last only on the 512th byte; busy clears after it.
2. Same request, BLOCK_ADDR=1, req_sector=0x12345 -> sd_address=0x00012345; sd_rd held until sd_ready=0, then low within 1 cycle.
3. m_ready toggling 1/0 every cycle plus a 100-cycle stall at byte 300 -> no byte lost or duplicated, data stable during the stall, 512 handshakes total.
4. BFM stops after 100 bytes, TIMEOUT_CYCLES=1000 -> err_timeout=1 about 1000 cycles later, no m_valid at any point, return to IDLE; the next request clears err_timeout.
5. sd_byte_available held high for 3 cycles per byte -> exactly 512 captures.
6. reset asserted at byte 200 of FILL -> all outputs at reset values the next cycle; a fresh request completes correctly.
